// File: rtl/pc_ctrl_pkg.sv
// Shared opcode constants, FSM state type and alignment helper for the PC controller.
package pc_ctrl_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {BOOT, RUN, TRAP} pc_state_e;

    // Only the two LSBs matter; JALR targets arrive with bit 0 already cleared.
    function automatic logic is_misaligned(input logic [1:0] target_lo,
                                           input int unsigned ialign);
        if (ialign == 2) begin
            return target_lo[0];
        end
        return target_lo != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-fetch-target selection and misalignment detection.
module pc_target_calc
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic            branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] jalr_sum;

    assign seq_pc   = pc + XLEN'(4);
    assign rel_pc   = pc + imm;
    assign jalr_sum = rs1 + imm;

    always_comb begin
        target = seq_pc;
        case (opcode)
            OP_BRANCH: target = branch ? rel_pc : seq_pc;
            OP_JAL:    target = rel_pc;
            OP_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            default:   target = seq_pc;
        endcase
    end

    assign misaligned = is_misaligned(target[1:0], IALIGN);

endmodule

// File: rtl/pc_ctrl_param.sv
// Fetch PC register with branch/JAL/JALR redirect, stall handshake and misaligned-target trap.
// Optional performance counters are enabled by defining PC_PERF_CNT_EN.
module pc_ctrl_param
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     IALIGN       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Branch,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] RS1_in,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] pc_link,
`ifdef PC_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_redirect_cnt,
`endif
    output logic            misalign_exc,
    output logic [XLEN-1:0] exc_epc,
    output logic [XLEN-1:0] exc_tval
);

    pc_state_e       state;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            advance;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .pc         (PC),
        .opcode     (opcode),
        .branch     (Branch),
        .imm        (Imm),
        .rs1        (RS1_in),
        .target     (target),
        .misaligned (misaligned)
    );

    assign pc_link = PC + XLEN'(4);
    assign advance = (state == RUN) && pc_valid && fetch_ready && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            PC           <= RESET_VECTOR;
            pc_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            exc_epc      <= '0;
            exc_tval     <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (advance) begin
                        if (misaligned) begin
                            state        <= TRAP;
                            PC           <= TRAP_VECTOR;
                            exc_epc      <= PC;
                            exc_tval     <= target;
                            pc_valid     <= 1'b0;
                            misalign_exc <= 1'b1;
                        end else begin
                            PC <= target;
                        end
                    end
                end
                TRAP: begin
                    state        <= RUN;
                    pc_valid     <= 1'b1;
                    misalign_exc <= 1'b0;
                end
                default: begin
                    state        <= BOOT;
                    pc_valid     <= 1'b0;
                    misalign_exc <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_PERF_CNT_EN
    // Redirect covers any non-sequential target, traps included.
    logic redirect;
    assign redirect = (target != pc_link);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else if (advance) begin
            if (perf_fetch_cnt != 32'hFFFF_FFFF) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
